// File: rtl/instr_decode_stage_if.sv
// Handshake and issued-field bundle between the instruction source, the decode stage and LOAD_BLOCK.
// The source side uses master and the decode stage uses slave.
interface instr_decode_stage_if #(
   parameter int CNT_W = 16
);
   logic             instr_valid;
   logic [31:0]      instr;
   logic             instr_ready;
   logic             stall;
   logic             flush;
   logic [6:0]       OPCODE;
   logic [19:0]      INP;
   logic [4:0]       RD;
   logic [2:0]       FUNCT3;
   logic [4:0]       RS1;
   logic [4:0]       RS2;
   logic [6:0]       FUNCT7;
   logic             issue_valid;
   logic             illegal;
   logic [CNT_W-1:0] retired_cnt;
   logic [CNT_W-1:0] illegal_cnt;

   modport master (
      output instr_valid, instr, stall, flush,
      input  instr_ready, OPCODE, INP, RD, FUNCT3, RS1, RS2, FUNCT7,
             issue_valid, illegal, retired_cnt, illegal_cnt
   );

   modport slave (
      input  instr_valid, instr, stall, flush,
      output instr_ready, OPCODE, INP, RD, FUNCT3, RS1, RS2, FUNCT7,
             issue_valid, illegal, retired_cnt, illegal_cnt
   );
endinterface

// File: rtl/instr_decode_stage.sv
// Decode stage: buffers incoming instructions in a small FIFO and issues at most one per cycle
// as registered fields, with OPCODE forced to NO_OPERATION whenever nothing legal is issued.
module instr_decode_stage #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   instr_decode_stage_if.slave bus
);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

   localparam logic [6:0] OP_LOAD_IMM = 7'b1111111;
   localparam logic [6:0] OP_ALU      = 7'b0110011;
   localparam logic [6:0] OP_NOP      = 7'b0000000;

   logic [31:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic [6:0]       r_opcode;
   logic [19:0]      r_inp;
   logic [4:0]       r_rd;
   logic [2:0]       r_funct3;
   logic [4:0]       r_rs1;
   logic [4:0]       r_rs2;
   logic [6:0]       r_funct7;
   logic             r_issue_valid;
   logic             r_illegal;
   logic [CNT_W-1:0] r_retired_cnt;
   logic [CNT_W-1:0] r_illegal_cnt;

   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic [31:0] w_head;
   logic [6:0]  w_head_op;
   logic        w_legal;

   // Ready depends on the registered count only, so a full buffer never accepts even while popping.
   assign w_full    = (r_count == FULL_CNT);
   assign w_empty   = (r_count == '0);
   assign w_push    = bus.instr_valid && !w_full && !bus.flush;
   assign w_pop     = !bus.stall && !bus.flush && !w_empty;
   assign w_head    = r_mem[r_rd_ptr];
   assign w_head_op = w_head[6:0];
   assign w_legal   = (w_head_op == OP_LOAD_IMM) || (w_head_op == OP_ALU) || (w_head_op == OP_NOP);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.instr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Illegal pops consume the entry but leave the operand fields of the last real issue in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opcode      <= '0;
         r_inp         <= '0;
         r_rd          <= '0;
         r_funct3      <= '0;
         r_rs1         <= '0;
         r_rs2         <= '0;
         r_funct7      <= '0;
         r_issue_valid <= 1'b0;
         r_illegal     <= 1'b0;
         r_retired_cnt <= '0;
         r_illegal_cnt <= '0;
      end else begin
         r_opcode      <= OP_NOP;
         r_issue_valid <= 1'b0;
         r_illegal     <= 1'b0;
         if (w_pop) begin
            if (w_legal) begin
               r_opcode      <= w_head_op;
               r_inp         <= w_head[31:12];
               r_rd          <= w_head[11:7];
               r_funct3      <= w_head[14:12];
               r_rs1         <= w_head[19:15];
               r_rs2         <= w_head[24:20];
               r_funct7      <= w_head[31:25];
               r_issue_valid <= 1'b1;
               r_retired_cnt <= r_retired_cnt + STAT_ONE;
            end else begin
               r_illegal <= 1'b1;
               if (r_illegal_cnt != '1) begin
                  r_illegal_cnt <= r_illegal_cnt + STAT_ONE;
               end
            end
         end
      end
   end

   assign bus.instr_ready = !w_full;
   assign bus.OPCODE      = r_opcode;
   assign bus.INP         = r_inp;
   assign bus.RD          = r_rd;
   assign bus.FUNCT3      = r_funct3;
   assign bus.RS1         = r_rs1;
   assign bus.RS2         = r_rs2;
   assign bus.FUNCT7      = r_funct7;
   assign bus.issue_valid = r_issue_valid;
   assign bus.illegal     = r_illegal;
   assign bus.retired_cnt = r_retired_cnt;
   assign bus.illegal_cnt = r_illegal_cnt;
endmodule
